// File: rtl/prim_share_masker_pkg.sv
// Shared constants and state encoding for the Boolean share masker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package prim_share_masker_pkg;

  // Default mask width and LFSR configuration.
  localparam int unsigned DefaultWidth    = 32;
  localparam logic [31:0] DefaultLfsrPoly = 32'h80200003;
  localparam logic [31:0] DefaultLfsrSeed = 32'h00000001;

  // Sparse one-hot state codes. Any other code is treated as a fault.
  localparam logic [2:0] StNeedSeed = 3'b001;
  localparam logic [2:0] StRun      = 3'b010;
  localparam logic [2:0] StError    = 3'b100;

  typedef enum logic [2:0] {
    NeedSeed = StNeedSeed,
    Run      = StRun,
    Error    = StError
  } state_e;

endpackage

// File: rtl/prim_share_masker_lfsr.sv
// Galois LFSR mask source with reseed mux and all-zero seed substitution.
// Latency: new state visible one cycle after step_i or seed_valid_i.
// Backpressure: none; advances only when step_i is asserted, and reseed wins over step.
module prim_share_masker_lfsr
  import prim_share_masker_pkg::*;
#(
  parameter int unsigned      Width       = DefaultWidth,
  parameter logic [Width-1:0] LfsrPoly    = Width'(DefaultLfsrPoly),
  parameter logic [Width-1:0] DefaultSeed = Width'(DefaultLfsrSeed)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  input  logic             seed_valid_i,
  input  logic [Width-1:0] seed_i,
  output logic [Width-1:0] state_o,
  output logic             zero_o
);

  logic [Width-1:0] lfsr_q;
  logic [Width-1:0] lfsr_next;
  logic [Width-1:0] seed_sub;

  // One right-shift Galois step; feedback taps applied when the shifted-out bit is 1.
  always_comb begin
    lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrPoly : '0);
  end

  // An all-zero seed would lock the LFSR, so substitute the default seed.
  always_comb begin
    seed_sub = (seed_i == '0) ? DefaultSeed : seed_i;
  end

  // Mask state register: reseed has priority over the per-word advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= DefaultSeed;
    end else if (seed_valid_i) begin
      lfsr_q <= seed_sub;
    end else if (step_i) begin
      lfsr_q <= lfsr_next;
    end
  end

  assign state_o = lfsr_q;
  // A zero state can only arise from corruption; the owner treats it as a fault.
  assign zero_o  = (lfsr_q == '0);

endmodule

// File: rtl/prim_share_masker.sv
// Splits each plaintext word into two XOR shares using a fresh LFSR mask (optional macro PRIM_SHARE_MASKER_SELFCHECK_EN).
// Latency: 1 cycle from accepted word to share_valid_o; full throughput while share_ready_i is high.
// Backpressure: data_ready_o drops while held shares are not taken; shares stay stable until share_ready_i.
module prim_share_masker
  import prim_share_masker_pkg::*;
#(
  parameter int unsigned      Width       = DefaultWidth,
  parameter logic [Width-1:0] LfsrPoly    = Width'(DefaultLfsrPoly),
  parameter logic [Width-1:0] DefaultSeed = Width'(DefaultLfsrSeed),
  parameter logic             RequireSeed = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  input  logic [Width-1:0] data_i,
  input  logic             seed_valid_i,
  input  logic [Width-1:0] seed_i,
  output logic             share_valid_o,
  input  logic             share_ready_i,
  output logic [Width-1:0] share0_o,
  output logic [Width-1:0] share1_o,
  output logic             err_o
);

  localparam state_e ResetState = RequireSeed ? NeedSeed : Run;

  state_e           state_q;
  state_e           state_d;
  logic             accept;
  logic             seed_take;
  logic             lfsr_zero;
  logic             selfcheck_fail;
  logic [Width-1:0] mask;

  // New words are taken only in Run, and only when the output slot is free or draining.
  assign data_ready_o = (state_q == Run) && (!share_valid_o || share_ready_i);
  assign accept       = data_valid_i && data_ready_o;
  // Reseeding a faulted block would hide the fault, so it is ignored in Error.
  assign seed_take    = seed_valid_i && (state_q != Error);
  assign err_o        = (state_q == Error);

  prim_share_masker_lfsr #(
    .Width       (Width),
    .LfsrPoly    (LfsrPoly),
    .DefaultSeed (DefaultSeed)
  ) u_lfsr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .step_i       (accept),
    .seed_valid_i (seed_take),
    .seed_i       (seed_i),
    .state_o      (mask),
    .zero_o       (lfsr_zero)
  );

`ifdef PRIM_SHARE_MASKER_SELFCHECK_EN
  logic [Width-1:0] shadow_q;

  // Keep the plaintext of the word currently held in the share registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else if (accept) begin
      shadow_q <= data_i;
    end
  end

  assign selfcheck_fail = share_valid_o && ((share0_o ^ share1_o) != shadow_q);
`else
  assign selfcheck_fail = 1'b0;
`endif

  // Control FSM: wait for the first seed, run, and latch any fault until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NeedSeed: if (seed_valid_i) state_d = Run;
      Run:      if (lfsr_zero || selfcheck_fail) state_d = Error;
      Error:    state_d = Error;
      default:  state_d = Error;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ResetState;
    end else begin
      state_q <= state_d;
    end
  end

  // Share registers: load both shares together so a mask never leaves unpaired;
  // valid drops on a handshake with no replacement word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      share_valid_o <= 1'b0;
      share0_o      <= '0;
      share1_o      <= '0;
    end else if (accept) begin
      share_valid_o <= 1'b1;
      share0_o      <= data_i ^ mask;
      share1_o      <= mask;
    end else if (share_valid_o && share_ready_i) begin
      share_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prim_share_masker.sv
// Scoreboard bench for prim_share_masker: directed vectors, stall, reseed, fault and random stream.
// Latency: expects shares one cycle after each accepted word.
// Backpressure: drives share_ready_i low/random and checks output stability and ordering.
module tb_prim_share_masker;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         data_valid_i;
  logic         data_ready_o;
  logic [W-1:0] data_i;
  logic         seed_valid_i;
  logic [W-1:0] seed_i;
  logic         share_valid_o;
  logic         share_ready_i;
  logic [W-1:0] share0_o;
  logic [W-1:0] share1_o;
  logic         err_o;

  int           total;
  int           bad;
  bit           rnd_rdy;
  logic [W-1:0] mdl;
  logic [2*W-1:0] exp_q[$];

  prim_share_masker dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .data_valid_i  (data_valid_i),
    .data_ready_o  (data_ready_o),
    .data_i        (data_i),
    .seed_valid_i  (seed_valid_i),
    .seed_i        (seed_i),
    .share_valid_o (share_valid_o),
    .share_ready_i (share_ready_i),
    .share0_o      (share0_o),
    .share1_o      (share1_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endfunction

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Monitor: every output handshake must match the oldest expected pair.
  always @(negedge clk) begin
    if (!rst && share_valid_o && share_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        chk("share0", share0_o, e[2*W-1:W]);
        chk("share1", share1_o, e[W-1:0]);
      end
    end
  end

  // Offer one word; push the given expected shares once it is accepted.
  task automatic send_exp(input logic [W-1:0] d, input logic [W-1:0] e0, input logic [W-1:0] e1);
    int n;
    n = 0;
    data_valid_i = 1'b1;
    data_i       = d;
    @(negedge clk);
    while (!data_ready_o && n < 100) begin
      @(posedge clk); #1;
      if (rnd_rdy) share_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (!data_ready_o) begin
      chk("send_timeout", 32'd1, 32'd0);
    end else begin
      exp_q.push_back({e0, e1});
      mdl = lfsr_step(mdl);
    end
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    if (rnd_rdy) share_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send_mdl(input logic [W-1:0] d);
    send_exp(d, d ^ mdl, mdl);
  endtask

  task automatic drain();
    int n;
    n = 0;
    share_ready_i = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; rnd_rdy = 1'b0; mdl = 32'h1;
    rst = 1'b1; data_valid_i = 1'b1; data_i = '0;
    seed_valid_i = 1'b0; seed_i = '0; share_ready_i = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_share_valid", 32'(share_valid_o), 32'd0);
    chk("rst_share0", share0_o, 32'h0);
    chk("rst_share1", share1_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Waiting for the first seed: no data accepted.
    @(negedge clk);
    chk("needseed_ready", 32'(data_ready_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("needseed_ready2", 32'(data_ready_o), 32'd0);
    chk("needseed_valid", 32'(share_valid_o), 32'd0);
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    seed_valid_i = 1'b1;
    seed_i       = 32'h1;
    @(posedge clk); #1;
    seed_valid_i = 1'b0;
    mdl = 32'h1;
    @(negedge clk);
    chk("run_ready", 32'(data_ready_o), 32'd1);
    @(posedge clk); #1;

    // Directed words with hand-computed shares.
    send_exp(32'hA5A5A5A5, 32'hA5A5A5A4, 32'h00000001);
    send_exp(32'h00000000, 32'h80200003, 32'h80200003);
    @(negedge clk);
    @(posedge clk); #1;

    // Stall with downstream not ready: shares hold, no new accept, mask frozen.
    share_ready_i = 1'b0;
    send_exp(32'h12345678, 32'hD204567A, 32'hC0300002);
    data_valid_i = 1'b1;
    data_i       = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(share_valid_o), 32'd1);
      chk("stall_share0", share0_o, 32'hD204567A);
      chk("stall_share1", share1_o, 32'hC0300002);
      chk("stall_ready", 32'(data_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    share_ready_i = 1'b1;
    @(negedge clk);
    chk("release_ready", 32'(data_ready_o), 32'd1);
    exp_q.push_back({32'h9FE7FFFE, 32'h60180001});
    mdl = 32'hB02C0003;
    @(posedge clk); #1;
    data_valid_i = 1'b0;

    // Zero reseed together with an accept: old mask used, then default seed.
    data_valid_i = 1'b1;
    data_i       = 32'h0000FFFF;
    seed_valid_i = 1'b1;
    seed_i       = 32'h0;
    @(negedge clk);
    chk("reseed_ready", 32'(data_ready_o), 32'd1);
    exp_q.push_back({32'hB02CFFFC, 32'hB02C0003});
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    seed_valid_i = 1'b0;
    mdl = 32'h1;
    send_exp(32'h11111111, 32'h11111110, 32'h00000001);
    drain();

    // Random stream with random downstream backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        share_ready_i = 1'($urandom_range(0, 1));
      end
      send_mdl($urandom());
    end
    rnd_rdy = 1'b0;
    drain();

    // Corrupt the mask state: sticky error, no data, reseed ignored.
    @(negedge clk);
    force dut.u_lfsr.lfsr_q = 32'h0;
    @(posedge clk); #1;
    release dut.u_lfsr.lfsr_q;
    data_valid_i = 1'b1;
    @(negedge clk);
    chk("fault_err", 32'(err_o), 32'd1);
    chk("fault_ready", 32'(data_ready_o), 32'd0);
    @(posedge clk); #1;
    seed_valid_i = 1'b1;
    seed_i       = 32'h5;
    @(posedge clk); #1;
    seed_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("fault_sticky_err", 32'(err_o), 32'd1);
    chk("fault_sticky_ready", 32'(data_ready_o), 32'd0);
    chk("fault_no_output", 32'(share_valid_o), 32'd0);
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("fault_cleared", 32'(err_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_needseed", 32'(data_ready_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
